// File: rtl/lsu_axi_lite.sv
// Load/store unit bridging a single-issue request port to an AXI4-Lite master.
// One outstanding transaction; misaligned accesses complete locally with an error.
module lsu_axi_lite #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [63:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [63:0]       WDATA,
  output logic [7:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_op, r_off;
  logic [ADDR_W-1:0] r_baddr;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;
  logic              r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
  logic              r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic              r_req_ready, r_resp_valid, r_resp_err;
  logic [63:0]       r_resp_rdata, w_rdata_nxt;
  logic              w_err_nxt, w_accept, w_misalign;
  logic [7:0]        w_strb_base, w_strb;
  logic [63:0]       w_shifted, w_load;
  logic              w_unused;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign ARADDR     = r_baddr;
  assign ARVALID    = r_arvalid;
  assign RREADY     = r_rready;
  assign AWADDR     = r_baddr;
  assign AWVALID    = r_awvalid;
  assign WDATA      = r_wdata;
  assign WSTRB      = r_wstrb;
  assign WVALID     = r_wvalid;
  assign BREADY     = r_bready;

  // Address bits above the bus width only matter for alignment of the low bits.
  assign w_unused = ^req_addr;

  // Size decode: stores and loads both size from op[1:0] (op 111 is a d access).
  always_comb begin
    w_misalign  = 1'b0;
    w_strb_base = 8'h01;
    case (req_op[1:0])
      2'b00: w_strb_base = 8'h01;
      2'b01: begin w_misalign = req_addr[0];      w_strb_base = 8'h03; end
      2'b10: begin w_misalign = |req_addr[1:0];   w_strb_base = 8'h0F; end
      default: begin w_misalign = |req_addr[2:0]; w_strb_base = 8'hFF; end
    endcase
  end

  assign w_strb    = w_strb_base << req_addr[2:0];
  assign w_shifted = RDATA >> {r_off, 3'b000};

  // Load data extraction: truncate to size then sign- or zero-extend.
  always_comb begin
    w_load = w_shifted;
    case (r_op)
      3'b000:  w_load = {{56{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load = {56'd0, w_shifted[7:0]};
      3'b101:  w_load = {48'd0, w_shifted[15:0]};
      3'b110:  w_load = {32'd0, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_rdata_nxt   = r_resp_rdata;
    w_err_nxt     = r_resp_err;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_misalign) begin
            w_state_nxt = RESP;
            w_rdata_nxt = 64'd0;
            w_err_nxt   = 1'b1;
          end else if (req_wr) begin
            w_state_nxt = AWW;
          end else begin
            w_state_nxt = AR;
          end
        end
      end
      AR: if (ARREADY) w_state_nxt = R;
      R: begin
        if (RVALID) begin
          w_state_nxt = RESP;
          w_err_nxt   = (RRESP != 2'b00);
          w_rdata_nxt = (RRESP != 2'b00) ? 64'd0 : w_load;
        end
      end
      AWW: begin
        // AW and W channels complete independently; leave once both have.
        w_aw_done_nxt = r_aw_done | (r_awvalid & AWREADY);
        w_w_done_nxt  = r_w_done  | (r_wvalid & WREADY);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt   = B;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      B: begin
        if (BVALID) begin
          w_state_nxt = RESP;
          w_err_nxt   = (BRESP != 2'b00);
          w_rdata_nxt = 64'd0;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_rdata_nxt = 64'd0;
        w_err_nxt   = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus-facing controls are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
      r_op         <= 3'd0;
      r_off        <= 3'd0;
      r_baddr      <= '0;
      r_wdata      <= 64'd0;
      r_wstrb      <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_aw_done    <= w_aw_done_nxt;
      r_w_done     <= w_w_done_nxt;
      r_arvalid    <= (w_state_nxt == AR);
      r_rready     <= (w_state_nxt == R);
      r_awvalid    <= (w_state_nxt == AWW) && !w_aw_done_nxt;
      r_wvalid     <= (w_state_nxt == AWW) && !w_w_done_nxt;
      r_bready     <= (w_state_nxt == B);
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      r_resp_rdata <= w_rdata_nxt;
      r_resp_err   <= w_err_nxt;
      if (w_accept) begin
        r_op    <= req_op;
        r_off   <= req_addr[2:0];
        r_baddr <= {req_addr[ADDR_W-1:3], 3'b000};
        r_wdata <= req_wdata << {req_addr[2:0], 3'b000};
        r_wstrb <= w_strb;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_lite.sv
// Directed bench for lsu_axi_lite: inputs driven and outputs sampled on the falling edge.
module tb_lsu_axi_lite;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_wr;
  logic [2:0]        req_op;
  logic [63:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [63:0]       resp_rdata;
  logic [ADDR_W-1:0] ARADDR, AWADDR;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [63:0]       RDATA, WDATA;
  logic [1:0]        RRESP, BRESP;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [7:0]        WSTRB;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] cap_araddr, cap_awaddr;
  logic [63:0]       cap_wdata;
  logic [7:0]        cap_wstrb;
  bit                saw_ar, saw_aw;

  always #5 clk = ~clk;

  lsu_axi_lite #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic idle_bus();
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 64'd0; RRESP = 2'b00;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
  endtask

  // Presents one request for one cycle; returns req_ready as seen in that cycle.
  task automatic drive_req(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                           input logic [63:0] wdata, output logic rdy);
    @(negedge clk);
    req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    rdy = req_ready;
    saw_ar = 1'b0; saw_aw = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Cycle index (1 = first cycle after accept) of resp_valid, -1 on timeout.
  task automatic wait_resp(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      if (ARVALID) begin saw_ar = 1'b1; cap_araddr = ARADDR; end
      if (AWVALID) begin saw_aw = 1'b1; cap_awaddr = AWADDR; end
      if (WVALID)  begin cap_wdata = WDATA; cap_wstrb = WSTRB; end
      if (resp_valid) begin cyc = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    idle_bus();
    repeat (3) @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_vec++; if (resp_rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    n_vec++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0) begin
      n_err++; $display("FAIL reset_axi got=%b exp=00000", {ARVALID, RREADY, AWVALID, WVALID, BREADY});
    end
    rst = 1'b0;
  endtask

  task automatic test_load_lb();
    logic rdy; int cyc;
    idle_bus();
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 64'h0000_0000_8000_0000;
    drive_req(1'b0, 3'b000, 64'h8000_0003, 64'd0, rdy);
    wait_resp(10, cyc);
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL lb_accept got=%b exp=1", rdy); end
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL lb_latency got=%0d exp=3", cyc); end
    n_vec++; if (cap_araddr !== 32'h8000_0000) begin n_err++; $display("FAIL lb_araddr got=%h exp=80000000", cap_araddr); end
    n_vec++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_rdata got=%h exp=ffffffffffffff80", resp_rdata); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL lb_err got=%b exp=0", resp_err); end
    @(negedge clk);
    n_vec++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL lb_after got=%b exp=01", {resp_valid, req_ready}); end
    idle_bus();
  endtask

  task automatic test_load_ext();
    logic [2:0]  ops  [9] = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b010, 3'b011, 3'b111, 3'b100, 3'b000};
    logic [2:0]  offs [9] = '{3'd2, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd1};
    logic [63:0] exps [9] = '{64'hFFFF_FFFF_FFFF_8899, 64'h0000_0000_0000_8899, 64'h0000_0000_1122_3344,
                              64'h0000_0000_8899_AABB, 64'hFFFF_FFFF_8899_AABB, 64'h1122_3344_8899_AABB,
                              64'h1122_3344_8899_AABB, 64'h0000_0000_0000_0011, 64'hFFFF_FFFF_FFFF_FFAA};
    logic rdy; int cyc;
    idle_bus();
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 64'h1122_3344_8899_AABB;
    for (int i = 0; i < 9; i++) begin
      drive_req(1'b0, ops[i], {61'h0200_0000, offs[i]}, 64'd0, rdy);
      wait_resp(10, cyc);
      n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL ext%0d_accept got=%b exp=1", i, rdy); end
      n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL ext%0d_latency got=%0d exp=3", i, cyc); end
      n_vec++; if (resp_rdata !== exps[i]) begin n_err++; $display("FAIL ext%0d_rdata got=%h exp=%h", i, resp_rdata, exps[i]); end
      n_vec++; if ({resp_err, req_ready} !== 2'b00) begin n_err++; $display("FAIL ext%0d_err_rdy got=%b exp=00", i, {resp_err, req_ready}); end
    end
    idle_bus();
  endtask

  task automatic test_store_sh();
    logic rdy; int cyc; bit got_bready;
    idle_bus();
    AWREADY = 1'b1; WREADY = 1'b1;
    drive_req(1'b1, 3'b001, 64'h8000_0006, 64'h1234, rdy);
    got_bready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (AWVALID) cap_awaddr = AWADDR;
      if (WVALID) begin cap_wdata = WDATA; cap_wstrb = WSTRB; end
      if (BREADY) begin got_bready = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (got_bready !== 1'b1) begin n_err++; $display("FAIL sh_bready got=%b exp=1", got_bready); end
    n_vec++; if (cap_awaddr !== 32'h8000_0000) begin n_err++; $display("FAIL sh_awaddr got=%h exp=80000000", cap_awaddr); end
    n_vec++; if (cap_wdata !== 64'h1234_0000_0000_0000) begin n_err++; $display("FAIL sh_wdata got=%h exp=1234000000000000", cap_wdata); end
    n_vec++; if (cap_wstrb !== 8'hC0) begin n_err++; $display("FAIL sh_wstrb got=%h exp=c0", cap_wstrb); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL sh_early_resp got=%b exp=0", resp_valid); end
    end
    BVALID = 1'b1;
    wait_resp(4, cyc);
    BVALID = 1'b0;
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL sh_resp_cycle got=%0d exp=2", cyc); end
    n_vec++; if ({resp_err, resp_rdata} !== 65'd0) begin n_err++; $display("FAIL sh_resp got=%b/%h exp=0/0", resp_err, resp_rdata); end
    idle_bus();
  endtask

  task automatic test_store_aw_late();
    logic rdy; int pulses;
    idle_bus();
    WREADY = 1'b1;
    drive_req(1'b1, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, rdy);
    n_vec++; if ({AWVALID, WVALID} !== 2'b11) begin n_err++; $display("FAIL awl_start got=%b exp=11", {AWVALID, WVALID}); end
    n_vec++; if ({WDATA, WSTRB} !== {64'hDEAD_BEEF_0000_0000, 8'hF0}) begin n_err++; $display("FAIL awl_w got=%h/%h exp=deadbeef00000000/f0", WDATA, WSTRB); end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      n_vec++; if ({AWVALID, WVALID, BREADY} !== 3'b100) begin n_err++; $display("FAIL awl_hold%0d got=%b exp=100", i, {AWVALID, WVALID, BREADY}); end
    end
    AWREADY = 1'b1;
    @(negedge clk);
    n_vec++; if ({AWVALID, WVALID, BREADY} !== 3'b001) begin n_err++; $display("FAIL awl_b got=%b exp=001", {AWVALID, WVALID, BREADY}); end
    AWREADY = 1'b0; BVALID = 1'b1;
    @(negedge clk);
    BVALID = 1'b0;
    n_vec++; if ({resp_valid, resp_err} !== 2'b10) begin n_err++; $display("FAIL awl_resp got=%b exp=10", {resp_valid, resp_err}); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL awl_extra_resp got=%0d exp=0", pulses); end
    idle_bus();
  endtask

  task automatic test_store_ext();
    logic rdy; int cyc;
    idle_bus();
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
    drive_req(1'b1, 3'b000, 64'h2000_0005, 64'hAB, rdy);
    wait_resp(10, cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL sb_latency got=%0d exp=3", cyc); end
    n_vec++; if ({cap_wdata, cap_wstrb} !== {64'h0000_AB00_0000_0000, 8'h20}) begin n_err++; $display("FAIL sb_w got=%h/%h exp=0000ab0000000000/20", cap_wdata, cap_wstrb); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL sb_err got=%b exp=0", resp_err); end
    BRESP = 2'b01;
    drive_req(1'b1, 3'b011, 64'h2000_0008, 64'h0102_0304_0506_0708, rdy);
    wait_resp(10, cyc);
    n_vec++; if (cap_awaddr !== 32'h2000_0008) begin n_err++; $display("FAIL sd_awaddr got=%h exp=20000008", cap_awaddr); end
    n_vec++; if ({cap_wdata, cap_wstrb} !== {64'h0102_0304_0506_0708, 8'hFF}) begin n_err++; $display("FAIL sd_w got=%h/%h exp=0102030405060708/ff", cap_wdata, cap_wstrb); end
    n_vec++; if ({resp_err, resp_rdata} !== {1'b1, 64'd0}) begin n_err++; $display("FAIL sd_bresp_err got=%b/%h exp=1/0", resp_err, resp_rdata); end
    idle_bus();
  endtask

  task automatic test_misaligned();
    logic rdy; bit any_valid;
    idle_bus();
    ARREADY = 1'b1; RVALID = 1'b1; AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
    drive_req(1'b0, 3'b010, 64'h8000_0002, 64'd0, rdy);
    n_vec++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 64'd0}) begin n_err++; $display("FAIL mis_lw_resp got=%b%b/%h exp=11/0", resp_valid, resp_err, resp_rdata); end
    any_valid = ARVALID;
    for (int i = 0; i < 3; i++) begin @(negedge clk); any_valid |= ARVALID | resp_valid; end
    n_vec++; if (any_valid !== 1'b0) begin n_err++; $display("FAIL mis_lw_quiet got=%b exp=0", any_valid); end
    drive_req(1'b1, 3'b001, 64'h8000_0001, 64'h55, rdy);
    n_vec++; if ({resp_valid, resp_err} !== 2'b11) begin n_err++; $display("FAIL mis_sh_resp got=%b exp=11", {resp_valid, resp_err}); end
    any_valid = AWVALID | WVALID;
    for (int i = 0; i < 3; i++) begin @(negedge clk); any_valid |= AWVALID | WVALID | BREADY; end
    n_vec++; if (any_valid !== 1'b0) begin n_err++; $display("FAIL mis_sh_quiet got=%b exp=0", any_valid); end
    idle_bus();
  endtask

  task automatic test_lwu_err_reset();
    logic rdy; int cyc; bit any_resp;
    idle_bus();
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 64'h0000_0000_FFFF_FFFF; RRESP = 2'b10;
    drive_req(1'b0, 3'b110, 64'h8000_0000, 64'd0, rdy);
    wait_resp(10, cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL lwu_latency got=%0d exp=3", cyc); end
    n_vec++; if ({resp_err, resp_rdata} !== {1'b1, 64'd0}) begin n_err++; $display("FAIL lwu_rresp got=%b/%h exp=1/0", resp_err, resp_rdata); end
    RVALID = 1'b0; RRESP = 2'b00;
    drive_req(1'b0, 3'b110, 64'h8000_0000, 64'd0, rdy);
    @(negedge clk);
    n_vec++; if (RREADY !== 1'b1) begin n_err++; $display("FAIL rst_in_r_pre got=%b exp=1", RREADY); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if ({RREADY, resp_valid, req_ready} !== 3'b001) begin n_err++; $display("FAIL rst_in_r_post got=%b exp=001", {RREADY, resp_valid, req_ready}); end
    RVALID = 1'b1;
    any_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); any_resp |= resp_valid | ARVALID | RREADY; end
    n_vec++; if (any_resp !== 1'b0) begin n_err++; $display("FAIL rst_abandon got=%b exp=0", any_resp); end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_load_lb();
    test_load_ext();
    test_store_sh();
    test_store_aw_late();
    test_store_ext();
    test_misaligned();
    test_lwu_err_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
